// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding and bit-timing defaults.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int TIMER_DEFAULT = 434;

    // Mid-bit offset used to land the start-bit sample in the centre of the bit.
    function automatic int half_period(input int timer);
        return timer / 2;
    endfunction

endpackage

// File: rtl/fifo.sv
// Show-ahead synchronous FIFO, B bits wide and 2**W words deep.
module fifo #(
    parameter int B = 8,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rd,
    input  logic         wr,
    input  logic [B-1:0] w_data,
    output logic [B-1:0] r_data,
    output logic         empty,
    output logic         full
);

    logic [B-1:0] mem [2**W];
    logic [W:0]   w_ptr;
    logic [W:0]   r_ptr;
    logic         do_wr;
    logic         do_rd;

    assign do_wr = wr & ~full;
    assign do_rd = rd & ~empty;

    // NOTE: the storage array is deliberately not reset so it can map onto RAM;
    // only the pointers are reset, and r_data is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (do_wr)
            mem[w_ptr[W-1:0]] <= w_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_ptr <= '0;
            r_ptr <= '0;
        end else begin
            if (do_wr)
                w_ptr <= w_ptr + (W+1)'(1);
            if (do_rd)
                r_ptr <= r_ptr + (W+1)'(1);
        end
    end

    // The extra pointer bit tells a full ring from an empty one.
    assign empty  = (w_ptr == r_ptr);
    assign full   = (w_ptr[W] != r_ptr[W]) && (w_ptr[W-1:0] == r_ptr[W-1:0]);
    assign r_data = empty ? '0 : mem[r_ptr[W-1:0]];

endmodule

// File: rtl/uart_receiver.sv
// Frame deserializer: synchronizer, start detect, mid-bit sampling, stop/parity checks.
// Parity checking is compiled in only when UART_RX_PARITY_CHECK_EN is defined and P=1.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int P     = 0,
    parameter int s     = 1,
    parameter int TIMER = TIMER_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           rdi,
    output logic           done,
    output logic [8+P-1:0] word,
    output logic           ferr_set,
    output logic           perr_set
);

    localparam int NB = 8 + P;
    localparam int TW = $clog2(TIMER);
    localparam logic [TW-1:0] FULL_LOAD = TW'(TIMER - 1);
    localparam logic [TW-1:0] HALF_LOAD = TW'(half_period(TIMER) - 1);

    rx_state_t       state, state_next;
    logic [TW-1:0]   timer, timer_next;
    logic [3:0]      cnt, cnt_next;
    logic [NB-1:0]   shreg, shreg_next;
    logic            sync1, sync2, sync_prev;
    logic [1:0]      live;
    logic            armed;
    logic            start_edge;
    logic            tick;

    // live[1] marks that sync2 now carries a real sample rather than its preset;
    // armed then waits for a genuine high so a line held low over reset is ignored.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            sync_prev <= 1'b1;
            live      <= 2'b00;
            armed     <= 1'b0;
            state     <= IDLE;
            timer     <= '0;
            cnt       <= '0;
            shreg     <= '0;
        end else begin
            sync1     <= rdi;
            sync2     <= sync1;
            sync_prev <= sync2;
            live      <= {live[0], 1'b1};
            armed     <= armed | (live[1] & sync2);
            state     <= state_next;
            timer     <= timer_next;
            cnt       <= cnt_next;
            shreg     <= shreg_next;
        end
    end

    assign start_edge = armed & sync_prev & ~sync2;
    assign tick       = (timer == '0);

    // NOTE: every output of this block gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        timer_next = tick ? timer : timer - TW'(1);
        cnt_next   = cnt;
        shreg_next = shreg;
        done       = 1'b0;
        ferr_set   = 1'b0;
        unique case (state)
            IDLE: begin
                timer_next = timer;
                if (start_edge) begin
                    state_next = START;
                    timer_next = HALF_LOAD;
                end
            end
            START: begin
                if (tick) begin
                    if (!sync2) begin
                        state_next = DATA;
                        timer_next = FULL_LOAD;
                        cnt_next   = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shreg_next = {sync2, shreg[NB-1:1]};
                    timer_next = FULL_LOAD;
                    if (cnt == 4'(NB - 1)) begin
                        state_next = STOP;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + 4'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    ferr_set   = ~sync2;
                    timer_next = FULL_LOAD;
                    if (cnt == 4'(s - 1)) begin
                        done       = 1'b1;
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt + 4'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign word = shreg;

`ifdef UART_RX_PARITY_CHECK_EN
    generate
        if (P == 1) begin : g_parity
            // Even parity: the XOR over data plus parity bit must be zero.
            assign perr_set = done & (^shreg);
        end else begin : g_no_parity
            assign perr_set = 1'b0;
        end
    endgenerate
`else
    assign perr_set = 1'b0;
`endif

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive path: deserializer feeding a show-ahead FIFO, plus sticky error flags.
// Optional parity checking is enabled by UART_RX_PARITY_CHECK_EN.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int P     = 0,
    parameter int W     = 4,
    parameter int s     = 1,
    parameter int TIMER = TIMER_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           rdi,
    input  logic           rd,
    input  logic           clr_err,
    output logic [8+P-1:0] r_data,
    output logic           empty,
    output logic           full,
    output logic           rx_tick,
    output logic           ferr,
    output logic           perr,
    output logic           oerr
);

    logic           done;
    logic [8+P-1:0] word;
    logic           ferr_set;
    logic           perr_set;
    logic           wr;

    uart_receiver #(
        .P     (P),
        .s     (s),
        .TIMER (TIMER)
    ) u_receiver (
        .clk      (clk),
        .reset    (reset),
        .rdi      (rdi),
        .done     (done),
        .word     (word),
        .ferr_set (ferr_set),
        .perr_set (perr_set)
    );

    // A frame finishing against a full FIFO is dropped even if rd frees a slot
    // in the same cycle.
    assign wr = done & ~full;

    fifo #(
        .B (8 + P),
        .W (W)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .rd     (rd),
        .wr     (wr),
        .w_data (word),
        .r_data (r_data),
        .empty  (empty),
        .full   (full)
    );

    // Set events take priority over clr_err.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_tick <= 1'b0;
            ferr    <= 1'b0;
            perr    <= 1'b0;
            oerr    <= 1'b0;
        end else begin
            rx_tick <= done;
            ferr    <= ferr_set | (ferr & ~clr_err);
            perr    <= perr_set | (perr & ~clr_err);
            oerr    <= (done & full) | (oerr & ~clr_err);
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: one P=0/s=1 instance and one P=1/s=2 instance, both W=2.
module tb_uart_rx_fifo;

    localparam int TB_TIMER = 16;

`ifdef UART_RX_PARITY_CHECK_EN
    localparam logic PERR_EN = 1'b1;
`else
    localparam logic PERR_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       clr_err;
    logic       rdi0, rd0, empty0, full0, rx_tick0, ferr0, perr0, oerr0;
    logic [7:0] r_data0;
    logic       rdi1, rd1, empty1, full1, rx_tick1, ferr1, perr1, oerr1;
    logic [8:0] r_data1;

    int n_cmp = 0;
    int n_err = 0;
    int ticks0 = 0;
    int ticks1 = 0;
    logic [8:0] q0[$];
    logic [8:0] q1[$];

    uart_rx_fifo #(.P(0), .W(2), .s(1), .TIMER(TB_TIMER)) u_p0 (
        .clk(clk), .reset(reset), .rdi(rdi0), .rd(rd0), .clr_err(clr_err),
        .r_data(r_data0), .empty(empty0), .full(full0), .rx_tick(rx_tick0),
        .ferr(ferr0), .perr(perr0), .oerr(oerr0)
    );

    uart_rx_fifo #(.P(1), .W(2), .s(2), .TIMER(TB_TIMER)) u_p1 (
        .clk(clk), .reset(reset), .rdi(rdi1), .rd(rd1), .clr_err(clr_err),
        .r_data(r_data1), .empty(empty1), .full(full1), .rx_tick(rx_tick1),
        .ferr(ferr1), .perr(perr1), .oerr(oerr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_tick0) ticks0 <= ticks0 + 1;
        if (rx_tick1) ticks1 <= ticks1 + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input int sel, input logic b);
        if (sel == 0) rdi0 = b;
        else          rdi1 = b;
        cycles(TB_TIMER);
    endtask

    // bad_stop selects which stop bit is driven low (-1: none).
    task automatic send_frame(input int sel, input logic [8:0] w, input int nbits,
                              input int nstop, input int bad_stop);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(sel, w[i]);
        for (int i = 0; i < nstop; i++) drive_bit(sel, (i == bad_stop) ? 1'b0 : 1'b1);
        if (sel == 0) rdi0 = 1'b1;
        else          rdi1 = 1'b1;
    endtask

    task automatic pop(input int sel, input string tag);
        logic [8:0] exp;
        logic [8:0] got;
        if (sel == 0) begin
            exp = (q0.size() != 0) ? q0.pop_front() : 'x;
            got = {1'b0, r_data0};
            rd0 = 1'b1;
        end else begin
            exp = (q1.size() != 0) ? q1.pop_front() : 'x;
            got = r_data1;
            rd1 = 1'b1;
        end
        check(tag, 32'(got), 32'(exp));
        cycles(1);
        rd0 = 1'b0;
        rd1 = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        cycles(1);
        clr_err = 1'b0;
    endtask

    int t;

    initial begin
        reset = 1'b1; rdi0 = 1'b0; rdi1 = 1'b1;
        rd0 = 1'b0; rd1 = 1'b0; clr_err = 1'b0;
        cycles(4);
        check("rst_empty0", 32'(empty0), 32'd1);
        check("rst_full0", 32'(full0), 32'd0);
        check("rst_rdata0", 32'(r_data0), 32'd0);
        check("rst_flags0", 32'({rx_tick0, ferr0, perr0, oerr0}), 32'd0);
        check("rst_empty1", 32'(empty1), 32'd1);
        check("rst_flags1", 32'({rx_tick1, ferr1, perr1, oerr1}), 32'd0);
        reset = 1'b0;

        // Line held low through reset release must not start a frame.
        cycles(60);
        check("low_over_reset_ticks", 32'(ticks0), 32'd0);
        check("low_over_reset_empty", 32'(empty0), 32'd1);
        rdi0 = 1'b1;
        cycles(40);

        t = ticks0;
        q0.push_back(9'h0A5);
        send_frame(0, 9'h0A5, 8, 1, -1);
        cycles(3);
        check("a5_ticks", 32'(ticks0 - t), 32'd1);
        check("a5_empty", 32'(empty0), 32'd0);
        pop(0, "a5_data");
        check("a5_empty_after_rd", 32'(empty0), 32'd1);

        // Quarter-bit glitch.
        t = ticks0;
        rdi0 = 1'b0;
        cycles(4);
        rdi0 = 1'b1;
        cycles(40);
        check("glitch_ticks", 32'(ticks0 - t), 32'd0);
        check("glitch_empty", 32'(empty0), 32'd1);
        check("glitch_ferr", 32'(ferr0), 32'd0);

        q0.push_back(9'h03C);
        send_frame(0, 9'h03C, 8, 1, 0);
        cycles(3);
        check("badstop_ferr", 32'(ferr0), 32'd1);
        pop(0, "badstop_data");
        pulse_clr();
        check("badstop_ferr_clr", 32'(ferr0), 32'd0);

        // Overrun: five back-to-back frames into a four-deep FIFO.
        t = ticks0;
        for (int i = 0; i < 5; i++) begin
            logic [8:0] w;
            w = 9'(8'h11 * (i + 1));
            if (i < 4) q0.push_back(w);
            send_frame(0, w, 8, 1, -1);
        end
        cycles(3);
        check("ovr_ticks", 32'(ticks0 - t), 32'd5);
        check("ovr_full", 32'(full0), 32'd1);
        check("ovr_oerr", 32'(oerr0), 32'd1);
        for (int i = 0; i < 4; i++) pop(0, $sformatf("ovr_data%0d", i));
        check("ovr_empty", 32'(empty0), 32'd1);
        pulse_clr();
        check("ovr_oerr_clr", 32'(oerr0), 32'd0);

        // Nine-bit frames with two stop bits.
        t = ticks1;
        q1.push_back(9'h1A5);
        send_frame(1, 9'h1A5, 9, 2, -1);
        cycles(3);
        check("par_odd_perr", 32'(perr1), 32'(PERR_EN));
        check("par_odd_ferr", 32'(ferr1), 32'd0);
        q1.push_back(9'h0A5);
        send_frame(1, 9'h0A5, 9, 2, -1);
        cycles(3);
        check("par_even_perr_sticky", 32'(perr1), 32'(PERR_EN));
        check("par_ticks", 32'(ticks1 - t), 32'd2);
        pulse_clr();
        check("par_perr_clr", 32'(perr1), 32'd0);
        pop(1, "par_data0");
        pop(1, "par_data1");

        q1.push_back(9'h0F0);
        send_frame(1, 9'h0F0, 9, 2, 1);
        cycles(3);
        check("stop2_ferr", 32'(ferr1), 32'd1);
        check("stop2_perr", 32'(perr1), 32'd0);
        pop(1, "stop2_data");
        pulse_clr();
        check("stop2_empty", 32'(empty1), 32'd1);

        // Reset in the middle of the data bits of 0x55.
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        cycles(TB_TIMER / 2);
        reset = 1'b1;
        rdi0 = 1'b1;
        cycles(2);
        reset = 1'b0;
        cycles(40);
        t = ticks0;
        check("midrst_empty", 32'(empty0), 32'd1);
        q0.push_back(9'h081);
        send_frame(0, 9'h081, 8, 1, -1);
        cycles(3);
        check("midrst_ticks", 32'(ticks0 - t), 32'd1);
        check("midrst_flags", 32'({ferr0, perr0, oerr0}), 32'd0);
        pop(0, "midrst_data");
        check("midrst_empty_end", 32'(empty0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
UART receive path: serial line rdi into a frame deserializer, then into a FIFO that the host drains.
- Receive counterpart of the FIFO-buffered UART transmitter; must interoperate with it for identical P/s/TIMER.
- Sits between the pad-side rdi pin and the host/peripheral bus.
- Detects start, samples mid-bit, checks stop/parity, flags framing/parity/overrun errors.

Parameters:
P, 0, parity bits per frame (0 or 1); data word width is 8+P.
W, 4, FIFO address width; depth 2**W words.
s, 1, stop bits per frame (1 or 2).
TIMER, 434, clk cycles per bit period (50 MHz / 115200); must be >= 4.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
rdi  in  1  asynchronous serial input, idle high.
rd  in  1  pop the head word; ignored while empty.
clr_err  in  1  one-cycle clear of all sticky error flags.
r_data  out  8+P  head word of the FIFO (show-ahead), LSB = first received bit.
empty  out  1  FIFO holds no words.
full  out  1  FIFO holds 2**W words.
rx_tick  out  1  one-cycle pulse when a frame completes (good or bad).
ferr  out  1  sticky framing error.
perr  out  1  sticky parity error (see Optional Feature).
oerr  out  1  sticky overrun, frame dropped because FIFO full.

Behaviour:
Reset values:
- FIFO empty: empty=1, full=0, r_data=0.
- rx_tick=0; ferr=perr=oerr=0.
- FSM in IDLE; sync flops preset to 1.
- Reset mid-frame discards the partial frame.

Input handling:
- rdi passes through a 2-flop synchronizer.
- A start edge is a 1->0 transition of the synchronized value.
- A line held low across reset release is not a start; it must go high first.

FSM states: IDLE, START, DATA, STOP.
- IDLE: on start edge, load bit timer, go to START.
- START: after TIMER/2 (floor) cycles, sample.
  - Sample 0: reload timer to TIMER, go to DATA.
  - Sample 1 (glitch): back to IDLE, no rx_tick, no flag.
- DATA: every TIMER cycles, shift sample into bit 7+P, shifting right (LSB first). After 8+P samples go to STOP.
- STOP: every TIMER cycles sample s stop bits.
  - Any stop sample = 0 sets ferr.
  - After the last stop sample go to IDLE.

Frame completion (last stop-sample cycle = T):
- Word written to FIFO at T if not full; otherwise dropped and oerr set.
- Words are written even when framing or parity is bad.
- rx_tick pulses at T+1.
- empty falls at T+1 when the word was written.
- Earliest next start edge is accepted at T+1, so back-to-back frames are supported.

FIFO rules:
- Write is gated by full evaluated at T.
- A rd in the same cycle does not rescue the write; the frame is dropped and oerr set.
- rd with empty=0 advances the head; new r_data appears the next cycle.
- Simultaneous write and rd when not full: both occur, count unchanged.
- Pointers wrap modulo 2**W.

Error flags:
- clr_err clears all three flags.
- If clr_err and a set event occur in the same cycle, set wins.

Optional Feature:
Macro UART_RX_PARITY_CHECK_EN.
- Defined and P=1: perr is set at T when XOR of all 9 received bits is 1 (even parity); the word is still written.
- Undefined, or P=0: perr tied 0 and parity logic removed.
- The received parity bit remains in r_data[8] either way.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state encoding (IDLE/START/DATA/STOP, 2 bits).
  - Default TIMER constant (434).
  - Helper constant for TIMER/2.
- Reuse the existing fifo (B=8+P, W=W) for buffering.
- One natural sub-module: uart_receiver (synchronizer, FSM, bit timer, shift register, error detect), producing a done pulse, frame word and error strobes.

Test Plan:
- TIMER=16, P=0, s=1: send 0xA5 -> rx_tick once, empty=0, r_data=0xA5; rd -> empty=1.
- 0.25-bit low glitch on rdi (4 cycles at TIMER=16) -> no rx_tick, FSM returns IDLE, FIFO unchanged.
- Stop bit driven 0 with data 0x3C -> ferr=1, r_data=0x3C written; clr_err -> ferr=0.
- W=2: send 5 frames without rd -> full after 4, 5th dropped, oerr=1, reading returns first 4 in order.
- P=1 with macro defined: send 9-bit 0x1A5 (odd parity) -> perr=1; send 0x0A5 -> perr unchanged until clr_err.
- Assert reset mid-DATA of 0x55, then send 0x81 -> only 0x81 received, all flags 0.
